// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//
// Shares the single pipelined DCache request port between the AGU
// (loads/stores) and the SPU (CACHE-op accesses) in the execute stage.
// One requester is granted per cycle, and that grant is held until the DCache
// accepts the request. The owner of every accepted request is recorded in an
// in-order owner FIFO, so each in-order response is routed back to the unit
// that issued it.
//
// Configuration:
//   DCACHE_ARB_RR_EN  defined   -> round-robin on a tie (requester not granted last wins)
//                     undefined -> fixed priority, SPU over AGU
//
// Ports:
//   clk, reset                    core clock, asynchronous active-low reset
//   flush                         pipeline flush, outstanding responses discarded
//   agu_* / spu_*                 requester side: req, wr, wstrb[3:0], size[2:0],
//                                 addr[31:0], wdata[31:0] in; addr_ok,
//                                 data_ok, rdata[31:0] out
//   dcache_*                      DCache side: req, wr, wstrb, size, addr, wdata
//                                 out; addr_ok, data_ok, rdata in
//   arb_busy                      requests outstanding or a grant held
//
// FSM states:
//   state    | meaning
//   IDLE     | no grant held, arbitrate among current requests
//   HOLD_AGU | AGU request presented, waiting for dcache_addr_ok
//   HOLD_SPU | SPU request presented, waiting for dcache_addr_ok
// -----------------------------------------------------------------------------
module dcache_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        agu_req,
    input  logic        agu_wr,
    input  logic [3:0]  agu_wstrb,
    input  logic [2:0]  agu_size,
    input  logic [31:0] agu_addr,
    input  logic [31:0] agu_wdata,
    output logic        agu_addr_ok,
    output logic        agu_data_ok,
    output logic [31:0] agu_rdata,

    input  logic        spu_req,
    input  logic        spu_wr,
    input  logic [3:0]  spu_wstrb,
    input  logic [2:0]  spu_size,
    input  logic [31:0] spu_addr,
    input  logic [31:0] spu_wdata,
    output logic        spu_addr_ok,
    output logic        spu_data_ok,
    output logic [31:0] spu_rdata,

    output logic        dcache_req,
    output logic        dcache_wr,
    output logic [3:0]  dcache_wstrb,
    output logic [2:0]  dcache_size,
    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_wdata,
    input  logic        dcache_addr_ok,
    input  logic        dcache_data_ok,
    input  logic [31:0] dcache_rdata,

    output logic        arb_busy
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic OWN_AGU = 1'b0;
    localparam logic OWN_SPU = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_AGU = 2'd1,
        HOLD_SPU = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [PW-1:0]              rd_ptr;
    logic [PW-1:0]              wr_ptr;
    logic [CW-1:0]              count;
    logic [MAX_OUTSTANDING-1:0] fifo_owner;
    logic [MAX_OUTSTANDING-1:0] fifo_discard;
    logic [MAX_OUTSTANDING-1:0] entry_valid;
    logic                       hold_flush;

    logic grant_vld;
    logic grant_own;
    logic idle_own;
    logic push;
    logic pop;
    logic room;
    logic head_own;
    logic head_disc;

    // An entry is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_valid
        logic [PW-1:0] offs;
        assign offs           = PW'(g) - rd_ptr;
        assign entry_valid[g] = ({1'b0, offs} < count);
    end

    assign pop       = dcache_data_ok && (count != '0);
    assign head_own  = fifo_owner[rd_ptr];
    assign head_disc = fifo_discard[rd_ptr];

    // A response popped this cycle frees the slot that this cycle's push uses,
    // so a full FIFO can still accept a new request alongside data_ok.
    assign room = (count < MAX_CNT) || pop;

`ifdef DCACHE_ARB_RR_EN
    logic last_grant;

    always_comb begin
        idle_own = spu_req ? OWN_SPU : OWN_AGU;
        if (agu_req && spu_req)
            idle_own = ~last_grant;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= OWN_AGU;
        else if (push)
            last_grant <= grant_own;
    end
`else
    always_comb begin
        idle_own = spu_req ? OWN_SPU : OWN_AGU;
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_own = OWN_AGU;
        case (state)
            IDLE: begin
                if (reset && !flush && room && (agu_req || spu_req)) begin
                    grant_vld = 1'b1;
                    grant_own = idle_own;
                    if (!dcache_addr_ok)
                        state_nxt = (idle_own == OWN_SPU) ? HOLD_SPU : HOLD_AGU;
                end
            end
            HOLD_AGU: begin
                grant_vld = 1'b1;
                grant_own = OWN_AGU;
                if (dcache_addr_ok)
                    state_nxt = IDLE;
            end
            HOLD_SPU: begin
                grant_vld = 1'b1;
                grant_own = OWN_SPU;
                if (dcache_addr_ok)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign push = grant_vld && dcache_addr_ok;

    always_comb begin
        dcache_req   = grant_vld;
        dcache_wr    = 1'b0;
        dcache_wstrb = '0;
        dcache_size  = '0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        if (grant_vld) begin
            if (grant_own == OWN_SPU) begin
                dcache_wr    = spu_wr;
                dcache_wstrb = spu_wstrb;
                dcache_size  = spu_size;
                dcache_addr  = spu_addr;
                dcache_wdata = spu_wdata;
            end else begin
                dcache_wr    = agu_wr;
                dcache_wstrb = agu_wstrb;
                dcache_size  = agu_size;
                dcache_addr  = agu_addr;
                dcache_wdata = agu_wdata;
            end
        end
    end

    assign agu_addr_ok = push && (grant_own == OWN_AGU);
    assign spu_addr_ok = push && (grant_own == OWN_SPU);

    assign agu_data_ok = pop && !head_disc && (head_own == OWN_AGU);
    assign spu_data_ok = pop && !head_disc && (head_own == OWN_SPU);
    assign agu_rdata   = agu_data_ok ? dcache_rdata : '0;
    assign spu_rdata   = spu_data_ok ? dcache_rdata : '0;

    assign arb_busy = (count != '0) || (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            fifo_owner   <= '0;
            fifo_discard <= '0;
            hold_flush   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (push) begin
                fifo_owner[wr_ptr] <= grant_own;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;

            // A flush poisons everything in flight, including the entry being
            // pushed now and a held request that is accepted later.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (push && (wr_ptr == PW'(i)))
                    fifo_discard[i] <= flush || hold_flush;
                else if (flush && entry_valid[i])
                    fifo_discard[i] <= 1'b1;
            end

            if (push)
                hold_flush <= 1'b0;
            else if (flush && (state != IDLE))
                hold_flush <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_data_ok : assert property (
        @(posedge clk) disable iff (!reset) !(dcache_data_ok && (count == '0))
    ) else $error("dcache_data_ok with no outstanding request");
`endif

endmodule
